// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ID/EX pipeline definitions: widths, ALU opcodes, control-bit positions,
// the packed bundle carried from ID to EX, and the stage occupancy encoding.
package id_ex_stage_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 4;
  localparam int CTRL_W     = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR = 4'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_SLL = 4'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_SRL = 4'd6;
  localparam logic [ALUOP_W-1:0] ALUOP_SRA = 4'd7;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT = 4'd8;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  typedef struct packed {
    logic [DATA_W-1:0]     read_data1;
    logic [DATA_W-1:0]     read_data2;
    logic [DATA_W-1:0]     immData;
    logic                  ALUSrc;
    logic [ALUOP_W-1:0]    ALUOp;
    logic [REG_ADDR_W-1:0] rd;
    logic [CTRL_W-1:0]     ctrl;
  } idex_bundle_t;

  // Encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } stage_state_e;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX bundle interface. Handshake: a transfer happens on a rising edge where
// valid & ready are both high; valid never depends on ready, and the stage's
// id_ready is purely registered.
interface id_ex_stage_reg_if;
  import id_ex_stage_reg_pkg::*;

  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_W-1:0]     id_read_data1;
  logic [DATA_W-1:0]     id_read_data2;
  logic [DATA_W-1:0]     id_immData;
  logic                  id_ALUSrc;
  logic [ALUOP_W-1:0]    id_ALUOp;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [CTRL_W-1:0]     id_ctrl;
  logic                  flush;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_W-1:0]     ex_read_data1;
  logic [DATA_W-1:0]     ex_read_data2;
  logic [DATA_W-1:0]     ex_immData;
  logic                  ex_ALUSrc;
  logic [ALUOP_W-1:0]    ex_ALUOp;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [CTRL_W-1:0]     ex_ctrl;

  modport master (
    output id_valid, id_read_data1, id_read_data2, id_immData, id_ALUSrc,
           id_ALUOp, id_rd, id_ctrl, flush, ex_ready,
    input  id_ready, ex_valid, ex_read_data1, ex_read_data2, ex_immData,
           ex_ALUSrc, ex_ALUOp, ex_rd, ex_ctrl
  );

  modport slave (
    input  id_valid, id_read_data1, id_read_data2, id_immData, id_ALUSrc,
           id_ALUOp, id_rd, id_ctrl, flush, ex_ready,
    output id_ready, ex_valid, ex_read_data1, ex_read_data2, ex_immData,
           ex_ALUSrc, ex_ALUOp, ex_rd, ex_ctrl
  );

endinterface

// File: rtl/id_ex_stage_reg_bundle_reg.sv
// Load-enable storage for one ID/EX bundle; cleared by synchronous reset.
module id_ex_bundle_reg
  import id_ex_stage_reg_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  idex_bundle_t d,
  output idex_bundle_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX stage register as a 2-entry skid buffer: main drives EX, skid catches the
// bundle accepted while EX stalls, so id_ready never depends on ex_ready.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_reg_if.slave bus,
  output stage_state_e     dbg_state
);

  stage_state_e state_q;
  stage_state_e state_d;
  idex_bundle_t id_bundle;
  idex_bundle_t main_d;
  idex_bundle_t main_q;
  idex_bundle_t skid_q;
  logic         main_load;
  logic         main_from_skid;
  logic         skid_load;
  logic         id_ready;
  logic         main_valid;
  logic         accept;
  logic         consume;

  assign id_bundle = '{read_data1: bus.id_read_data1,
                       read_data2: bus.id_read_data2,
                       immData:    bus.id_immData,
                       ALUSrc:     bus.id_ALUSrc,
                       ALUOp:      bus.id_ALUOp,
                       rd:         bus.id_rd,
                       ctrl:       bus.id_ctrl};

  assign main_valid = (state_q != ST_EMPTY);
  assign id_ready   = (state_q != ST_FULL2);
  assign accept     = bus.id_valid & id_ready;
  assign consume    = main_valid & bus.ex_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (consume && accept) begin
          main_load = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = ST_FULL2;
        end
      end
      ST_FULL2: begin
        if (consume) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_FULL1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only drops occupancy; payload written this cycle is dead once invalid.
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end
  end

  assign main_d = main_from_skid ? skid_q : id_bundle;

  id_ex_bundle_reg u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  id_ex_bundle_reg u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (id_bundle),
    .q     (skid_q)
  );

  assign bus.id_ready      = id_ready;
  assign bus.ex_valid      = main_valid;
  assign bus.ex_read_data1 = main_q.read_data1;
  assign bus.ex_read_data2 = main_q.read_data2;
  assign bus.ex_immData    = main_q.immData;
  assign bus.ex_ALUSrc     = main_q.ALUSrc;
  assign bus.ex_ALUOp      = main_q.ALUOp;
  assign bus.ex_rd         = main_q.rd;
  assign bus.ex_ctrl       = main_q.ctrl;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vectors plus a random valid/ready/flush run,
// checked by an in-order scoreboard and a stall-stability monitor.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int BW = $bits(idex_bundle_t);

  logic         clk = 1'b0;
  logic         reset;
  stage_state_e dbg_state;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [BW-1:0] exp_q[$];

  id_ex_stage_reg_if bus ();

  id_ex_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic idex_bundle_t mk(input logic [31:0] rd1, input logic [31:0] rd2,
                                      input logic [31:0] imm, input logic src,
                                      input logic [3:0] op, input logic [4:0] rd,
                                      input logic [3:0] ctrl);
    idex_bundle_t b;
    b.read_data1 = rd1;
    b.read_data2 = rd2;
    b.immData    = imm;
    b.ALUSrc     = src;
    b.ALUOp      = op;
    b.rd         = rd;
    b.ctrl       = ctrl;
    return b;
  endfunction

  function automatic idex_bundle_t rand_bundle();
    return mk($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 8)), 5'($urandom_range(0, 31)),
              4'($urandom_range(0, 15)));
  endfunction

  function automatic idex_bundle_t ex_now();
    return mk(bus.ex_read_data1, bus.ex_read_data2, bus.ex_immData, bus.ex_ALUSrc,
              bus.ex_ALUOp, bus.ex_rd, bus.ex_ctrl);
  endfunction

  function automatic logic [31:0] ex_op2();
    return bus.ex_ALUSrc ? bus.ex_immData : bus.ex_read_data2;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at posedge+1, returns at the next posedge+1
  task automatic drive(input logic v, input idex_bundle_t b, input logic er, input logic fl);
    bus.id_valid      = v;
    bus.id_read_data1 = b.read_data1;
    bus.id_read_data2 = b.read_data2;
    bus.id_immData    = b.immData;
    bus.id_ALUSrc     = b.ALUSrc;
    bus.id_ALUOp      = b.ALUOp;
    bus.id_rd         = b.rd;
    bus.id_ctrl       = b.ctrl;
    bus.ex_ready      = er;
    bus.flush         = fl;
    @(negedge clk);
    #1;
    if (reset || fl) exp_q.delete();
    else if (v && bus.id_ready) exp_q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  logic         prev_stall = 1'b0;
  idex_bundle_t prev_b;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 128'(bus.ex_valid), 128'(1'b1));
        check("stall_hold", 128'(ex_now()), 128'(prev_b));
      end
      if (bus.ex_valid && bus.ex_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected nothing at %0t", ex_now(), $time);
        end else begin
          check("scoreboard", 128'(ex_now()), 128'(exp_q.pop_front()));
        end
      end
      prev_stall = bus.ex_valid && !bus.ex_ready && !bus.flush;
      prev_b     = ex_now();
    end
  end

  idex_bundle_t zb, a, b, c, d, e, f;

  initial begin
    zb = '0;
    a  = mk(32'h1, 32'h11, 32'hA0, 1'b0, ALUOP_ADD, 5'd1, 4'b1000);
    b  = mk(32'h2, 32'h22, 32'hB0, 1'b1, ALUOP_SUB, 5'd2, 4'b1100);
    c  = mk(32'h3, 32'h33, 32'hC0, 1'b0, ALUOP_XOR, 5'd3, 4'b0010);
    d  = mk(32'hFFFF_FFFF, 32'h44, 32'h8000_0000, 1'b1, ALUOP_SRA, 5'd31, 4'b1001);
    e  = mk(32'hDEAD_BEEF, 32'h55, 32'h0, 1'b0, ALUOP_SLT, 5'd7, 4'b0110);
    f  = mk(32'h6, 32'h66, 32'h60, 1'b1, ALUOP_OR, 5'd6, 4'b1111);

    reset = 1'b1;
    bus.id_valid = 1'b0; bus.ex_ready = 1'b0; bus.flush = 1'b0;
    bus.id_read_data1 = '0; bus.id_read_data2 = '0; bus.id_immData = '0;
    bus.id_ALUSrc = 1'b0; bus.id_ALUOp = '0; bus.id_rd = '0; bus.id_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", 128'(bus.ex_valid), 128'(1'b0));
    check("rst_id_ready", 128'(bus.id_ready), 128'(1'b1));
    check("rst_payload", 128'(ex_now()), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(ST_EMPTY));
    reset = 1'b0;
    drive(1'b0, zb, 1'b0, 1'b0);
    check("idle_ex_valid", 128'(bus.ex_valid), 128'(1'b0));

    // streaming, 1-cycle latency, operand-2 select seen by EX
    drive(1'b1, a, 1'b1, 1'b0);
    check("s_a_valid", 128'(bus.ex_valid), 128'(1'b1));
    check("s_a_op2", 128'(ex_op2()), 128'(32'h11));
    drive(1'b1, b, 1'b1, 1'b0);
    check("s_b_op2", 128'(ex_op2()), 128'(32'hB0));
    check("s_b_ctrl_regwrite", 128'(bus.ex_ctrl[CTRL_REGWRITE]), 128'(1'b1));
    drive(1'b1, c, 1'b1, 1'b0);
    check("s_c_op2", 128'(ex_op2()), 128'(32'h33));
    drive(1'b0, zb, 1'b1, 1'b0);
    check("s_drained", 128'(bus.ex_valid), 128'(1'b0));

    // stall into skid, then release
    drive(1'b1, d, 1'b0, 1'b0);
    check("k_d_rd2", 128'(bus.ex_read_data2), 128'(32'h44));
    check("k_ready_full1", 128'(bus.id_ready), 128'(1'b1));
    drive(1'b1, e, 1'b0, 1'b0);
    check("k_hold_d", 128'(bus.ex_read_data2), 128'(32'h44));
    check("k_ready_full2", 128'(bus.id_ready), 128'(1'b0));
    check("k_state_full2", 128'(dbg_state), 128'(ST_FULL2));
    drive(1'b1, f, 1'b0, 1'b0);
    drive(1'b0, zb, 1'b1, 1'b0);
    check("k_e_in_main", 128'(bus.ex_read_data2), 128'(32'h55));
    check("k_ready_back", 128'(bus.id_ready), 128'(1'b1));
    drive(1'b0, zb, 1'b1, 1'b0);
    check("k_empty", 128'(bus.ex_valid), 128'(1'b0));

    // flush in FULL2 with a same-cycle input
    drive(1'b1, a, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0);
    drive(1'b1, c, 1'b0, 1'b1);
    check("f_ex_valid", 128'(bus.ex_valid), 128'(1'b0));
    check("f_id_ready", 128'(bus.id_ready), 128'(1'b1));
    drive(1'b0, zb, 1'b1, 1'b0);
    check("f_stays_empty", 128'(bus.ex_valid), 128'(1'b0));

    // reset while stalled in FULL2
    drive(1'b1, d, 1'b0, 1'b0);
    drive(1'b1, e, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, f, 1'b0, 1'b0);
    check("r_ex_valid", 128'(bus.ex_valid), 128'(1'b0));
    check("r_id_ready", 128'(bus.id_ready), 128'(1'b1));
    check("r_payload", 128'(ex_now()), 128'(0));
    reset = 1'b0;

    // random valid/ready/flush
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_bundle(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    repeat (4) drive(1'b0, zb, 1'b1, 1'b0);
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
